// File: rtl/kernel_bank_loader.sv
// kernel_bank_loader: on a start pulse, streams up to NUM_KERNELS kernels of
// a run-time element count from weight BRAM into the kernel register bank.
// Reads are issued one per cycle; a BRAM_LATENCY-deep tag pipeline lines each
// read up with the cycle its data appears, so writes land one per cycle too.
//
// Handshake: i_start is a request that is taken only while idle (o_busy=0)
// and i_abort is low. Every cycle of the load is tracked by o_busy, and the
// load finishes with a one-cycle o_done pulse. o_wr_en is a plain strobe with
// no back-pressure: the bank accepts every write in the cycle it is presented.
module kernel_bank_loader #(
  parameter int NUM_KERNELS     = 4,
  parameter int MAX_ELEMS       = 25,
  parameter int WEIGHT_WIDTH    = 8,
  parameter int BRAM_ADDR_WIDTH = 10,
  parameter int BRAM_LATENCY    = 1,
  localparam int EW = $clog2(MAX_ELEMS + 1),
  localparam int KW = $clog2(NUM_KERNELS + 1)
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic                       i_abort,
  input  logic [EW-1:0]              i_kernel_elems,
  input  logic [KW-1:0]              i_num_kernels,
  input  logic [BRAM_ADDR_WIDTH-1:0] i_start_addr,
  input  logic [BRAM_ADDR_WIDTH-1:0] i_kernel_stride,
  output logic                       o_bram_en,
  output logic [BRAM_ADDR_WIDTH-1:0] o_bram_addr,
  input  logic [WEIGHT_WIDTH-1:0]    i_bram_data,
  output logic                       o_wr_en,
  output logic [KW-1:0]              o_wr_kernel,
  output logic [EW-1:0]              o_wr_addr,
  output logic [WEIGHT_WIDTH-1:0]    o_wr_data,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_err,
  output logic [1:0]                 o_dbg_state
);

  localparam int AW = BRAM_ADDR_WIDTH;
  localparam int L  = BRAM_LATENCY;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [EW-1:0]       elems_q, elems_d;
  logic [KW-1:0]       nk_q, nk_d;
  logic [AW-1:0]       stride_q, stride_d;
  logic [AW-1:0]       base_q, base_d;
  logic [KW-1:0]       k_q, k_d;       // tag of the read currently on the bus
  logic [EW-1:0]       e_q, e_d;
  logic                bram_en_q, bram_en_d;
  logic [AW-1:0]       bram_addr_q, bram_addr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [L-1:0]        pipe_vld_q, pipe_vld_d;
  logic [L-1:0][KW-1:0] pipe_k_q, pipe_k_d;
  logic [L-1:0][EW-1:0] pipe_e_q, pipe_e_d;

  logic flush;
  logic req_bad;
  logic e_last;
  logic last_rd;
  logic early_pend;

  assign req_bad = (i_kernel_elems == '0) || (i_kernel_elems > EW'(MAX_ELEMS)) ||
                   (i_num_kernels == '0) || (i_num_kernels > KW'(NUM_KERNELS));
  assign e_last  = (e_q == elems_q - EW'(1));
  assign last_rd = e_last && (k_q == nk_q - KW'(1));

  // Reads still in flight ahead of the final pipeline stage.
  always_comb begin
    early_pend = 1'b0;
    for (int i = 0; i < L - 1; i++) begin
      early_pend = early_pend | pipe_vld_q[i];
    end
  end

  // Load sequencing: request capture, read address walk, drain and completion.
  always_comb begin
    state_d     = state_q;
    elems_d     = elems_q;
    nk_d        = nk_q;
    stride_d    = stride_q;
    base_d      = base_q;
    k_d         = k_q;
    e_d         = e_q;
    bram_addr_d = bram_addr_q;
    bram_en_d   = 1'b0;
    done_d      = 1'b0;
    err_d       = err_q;
    flush       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start && !i_abort) begin
          err_d    = 1'b0;
          elems_d  = i_kernel_elems;
          nk_d     = i_num_kernels;
          stride_d = i_kernel_stride;
          base_d   = i_start_addr;
          k_d      = '0;
          e_d      = '0;
          if (req_bad) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            bram_en_d   = 1'b1;
            bram_addr_d = i_start_addr;
            state_d     = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (i_abort) begin
          flush   = 1'b1;
          state_d = S_IDLE;
        end else if (last_rd) begin
          state_d = S_DRAIN;
        end else begin
          bram_en_d = 1'b1;
          if (e_last) begin
            // Kernel boundary: next base is taken in the same cycle, no bubble.
            e_d         = '0;
            k_d         = k_q + KW'(1);
            base_d      = base_q + stride_q;
            bram_addr_d = base_q + stride_q;
          end else begin
            e_d         = e_q + EW'(1);
            bram_addr_d = bram_addr_q + AW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (i_abort) begin
          flush   = 1'b1;
          state_d = S_IDLE;
        end else if (!early_pend) begin
          // The last write is in the final stage now; done follows it.
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Tag pipeline: each stage carries {valid, kernel, element} of one read.
  always_comb begin
    pipe_vld_d    = '0;
    pipe_k_d      = pipe_k_q;
    pipe_e_d      = pipe_e_q;
    pipe_vld_d[0] = bram_en_q & ~flush;
    pipe_k_d[0]   = k_q;
    pipe_e_d[0]   = e_q;
    for (int i = 1; i < L; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1] & ~flush;
      pipe_k_d[i]   = pipe_k_q[i-1];
      pipe_e_d[i]   = pipe_e_q[i-1];
    end
  end

  // State and output registers, all cleared by asynchronous reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      elems_q     <= '0;
      nk_q        <= '0;
      stride_q    <= '0;
      base_q      <= '0;
      k_q         <= '0;
      e_q         <= '0;
      bram_en_q   <= 1'b0;
      bram_addr_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      pipe_vld_q  <= '0;
      pipe_k_q    <= '0;
      pipe_e_q    <= '0;
    end else begin
      state_q     <= state_d;
      elems_q     <= elems_d;
      nk_q        <= nk_d;
      stride_q    <= stride_d;
      base_q      <= base_d;
      k_q         <= k_d;
      e_q         <= e_d;
      bram_en_q   <= bram_en_d;
      bram_addr_q <= bram_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_k_q    <= pipe_k_d;
      pipe_e_q    <= pipe_e_d;
    end
  end

  assign o_bram_en   = bram_en_q;
  assign o_bram_addr = bram_addr_q;
  assign o_wr_en     = pipe_vld_q[L-1];
  assign o_wr_kernel = pipe_k_q[L-1];
  assign o_wr_addr   = pipe_e_q[L-1];
  assign o_wr_data   = i_bram_data;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_err       = err_q;
  assign o_dbg_state = state_q;

endmodule

// File: doc/kernel_bank_loader.md
# kernel_bank_loader

Multi-kernel weight loader for the NPU convolution front end. On a start pulse it streams NUM_KERNELS-or-fewer kernels, each of a run-time element count, from weight BRAM into the kernel register bank. The BRAM read latency is a parameter, and reads are pipelined at one element per cycle. It validates the request, supports per-kernel address stride and abort, and reports completion with a single-cycle done pulse.

## Interface
- NUM_KERNELS, 4, kernel slots in the register bank (output channels)
- MAX_ELEMS, 25, maximum elements per kernel (5x5)
- WEIGHT_WIDTH, 8, weight bit width
- BRAM_ADDR_WIDTH, 10, weight BRAM address width
- BRAM_LATENCY, 1, cycles from o_bram_en to valid i_bram_data (1..4)
- Derived: EW = clog2(MAX_ELEMS+1), KW = clog2(NUM_KERNELS+1)

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_start  in  1  start request; sampled only in IDLE
- i_abort  in  1  abort current load; highest priority after reset
- i_kernel_elems  in  EW  elements per kernel, valid 1..MAX_ELEMS
- i_num_kernels  in  KW  kernels to load, valid 1..NUM_KERNELS
- i_start_addr  in  BRAM_ADDR_WIDTH  BRAM address of element 0 of kernel 0
- i_kernel_stride  in  BRAM_ADDR_WIDTH  address distance between successive kernel bases
- o_bram_en  out  1  BRAM read enable
- o_bram_addr  out  BRAM_ADDR_WIDTH  BRAM read address
- i_bram_data  in  WEIGHT_WIDTH  BRAM read data
- o_wr_en  out  1  register-bank write strobe
- o_wr_kernel  out  KW  destination kernel slot
- o_wr_addr  out  EW  destination element index
- o_wr_data  out  WEIGHT_WIDTH  write data, equals i_bram_data (combinational)
- o_busy  out  1  load in progress
- o_done  out  1  one-cycle completion pulse
- o_err  out  1  request rejected; holds until the next accepted i_start

## Operation
- On reset, all registered outputs are 0: o_bram_en, o_bram_addr, o_wr_en, o_wr_kernel, o_wr_addr, o_busy, o_done and o_err. The state is IDLE and the tag pipeline is empty.
- States:
  - IDLE
  - ISSUE
  - DRAIN
  - DONE
- IDLE, on i_start:
  - Latch all request inputs and clear o_err.
  - If i_kernel_elems==0, i_kernel_elems>MAX_ELEMS, i_num_kernels==0 or i_num_kernels>NUM_KERNELS, set o_err=1 and go to DONE. No BRAM read is issued.
  - Otherwise go to ISSUE with element counter e=0, kernel counter k=0 and base=i_start_addr.
- ISSUE:
  - Each cycle: o_bram_en=1 and o_bram_addr=base+e, modulo 2^BRAM_ADDR_WIDTH (wrap-around is allowed, not an error).
  - Push the tag (k,e) into a BRAM_LATENCY-deep valid/tag shift pipeline.
  - Advance e. When e reaches elems-1, set e=0, k=k+1 and base=base+stride (also modulo).
  - After the read for (num_kernels-1, elems-1), go to DRAIN.
- Write side: when the pipeline output is valid, assert o_wr_en=1 with o_wr_kernel and o_wr_addr taken from the tag, in the same cycle i_bram_data is valid.
- DRAIN: o_bram_en=0. Wait until the pipeline is empty, then go to DONE.
- DONE: o_done=1 for exactly one cycle, then go to IDLE.
- o_busy is 1 in ISSUE, DRAIN and DONE, and 0 in IDLE.
- i_start in any non-IDLE state is ignored and is not queued.
- i_abort in ISSUE or DRAIN:
  - Next cycle the state is IDLE, o_bram_en=0 and the pipeline is flushed, so no further o_wr_en is asserted.
  - o_done is not pulsed and o_err is unchanged.
- i_abort in IDLE or DONE has no effect.
- i_start and i_abort both high in IDLE: abort wins and the start is dropped.
- Reset mid-load: immediate return to the reset values. Partial bank contents are not restored.

## Timing
- i_start is sampled at edge 0. o_bram_en rises in cycle 1.
- Read n (n=0..N-1, N=elems*kernels) is issued in cycle 1+n. Its write occurs in cycle 1+n+BRAM_LATENCY.
- Last write is in cycle N+BRAM_LATENCY. o_done is in cycle N+BRAM_LATENCY+1. o_busy covers cycles 1..N+BRAM_LATENCY+1.
- Throughput: one weight per cycle, with no bubbles at kernel boundaries.
- Error path: o_err=1 and o_done=1 in cycle 1, o_busy=1 in cycle 1 only.
- Earliest next accepted start: the cycle after o_done.

## Test plan
- Parameters: NUM_KERNELS=4, MAX_ELEMS=25, BRAM_LATENCY=1. Request: elems=9, kernels=1, start=0x040.
  - Reads 0x040..0x048 in cycles 1..9.
  - Writes (k0,e0..e8) in cycles 2..10 with matching data.
  - o_done in cycle 11, o_err=0.
- Request: elems=9, kernels=3, start=0x100, stride=0x010, BRAM_LATENCY=3.
  - Addresses 0x100..0x108, 0x110..0x118, 0x120..0x128, back-to-back in cycles 1..27.
  - Writes tagged k0..k2 in cycles 4..30. o_done in cycle 31.
- Request: start=0x3FE, elems=4, kernels=1.
  - Addresses 0x3FE, 0x3FF, 0x000, 0x001. No error.
- Requests elems=0; elems=26; kernels=5.
  - Each: o_err=1 and o_done=1 in cycle 1, zero o_bram_en and zero o_wr_en.
  - o_err clears on the next valid start.
- Request elems=25, kernels=4 with i_abort in cycle 10.
  - Cycle 11: o_busy=0, o_bram_en=0.
  - No o_wr_en after cycle 10, no o_done.
  - A new i_start is accepted in cycle 11.
- Asserting i_start in mid-load, and asserting i_rst in cycle 5 of a load, run as two separate checks.
  - Mid-load start: ignored, the sequence is unchanged.
  - Mid-load reset: all outputs go to 0 asynchronously, and the next load is correct.
